// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control unit: control bundle, opcode names
// and the halt-drain FSM state encoding.
package ctrl_pkg;

  localparam int OP_W  = 4;
  localparam int REG_W = 4;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       brsrc;
    logic       pcs;
    logic       mem_read;
    logic       mem_write;
    logic       regwrite;
    logic       memtoreg;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fsm_e;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Connection between the IF/ID datapath side and the control pipeline.
interface ctrl_pipe_if #(
  parameter int OP_W  = ctrl_pkg::OP_W,
  parameter int REG_W = ctrl_pkg::REG_W
);
  logic [OP_W-1:0]  id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rd;
  logic             flush_i;
  logic             mem_stall_i;
  logic [2:0]       ex_aluop;
  logic             ex_alusrc;
  logic             ex_regdst;
  logic             ex_branch;
  logic             ex_brsrc;
  logic             ex_pcs;
  logic             mem_read;
  logic             mem_write;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic             stall_o;
  logic             halted_o;

  modport master (
    output id_opcode, id_rs, id_rt, ex_rd, flush_i, mem_stall_i,
    input  ex_aluop, ex_alusrc, ex_regdst, ex_branch, ex_brsrc, ex_pcs,
           mem_read, mem_write, wb_regwrite, wb_memtoreg, stall_o, halted_o
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_rd, flush_i, mem_stall_i,
    output ex_aluop, ex_alusrc, ex_regdst, ex_branch, ex_brsrc, ex_pcs,
           mem_read, mem_write, wb_regwrite, wb_memtoreg, stall_o, halted_o
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus which source registers
// the instruction actually reads (for load-use hazard detection).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs_o,
  output logic       uses_rt_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    ctrl_o    = CTRL_BUBBLE;
    uses_rs_o = 1'b0;
    uses_rt_o = 1'b0;
    if (!op_i[3]) begin
      ctrl_o.aluop    = op_i[2:0];
      ctrl_o.regwrite = 1'b1;
      ctrl_o.regdst   = 1'b1;
      ctrl_o.alusrc   = op_i[2] && (op_i[1:0] != 2'b11);
      uses_rs_o       = 1'b1;
      uses_rt_o       = !op_i[2];
    end else begin
      case (op_i)
        OP_LW: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.memtoreg = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
          uses_rs_o       = 1'b1;
        end
        OP_SW: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alusrc    = 1'b1;
          uses_rs_o        = 1'b1;
          uses_rt_o        = 1'b1;
        end
        OP_LLB, OP_LHB: begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
        end
        OP_B, OP_BR: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.brsrc  = op_i[0];
          uses_rs_o     = op_i[0];
        end
        OP_PCS: begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regdst   = 1'b1;
          ctrl_o.pcs      = 1'b1;
        end
        OP_HLT:  ctrl_o.halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB control registers with load-use
// stall, branch flush, memory freeze and a halt-drain FSM.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  ctrl_t            id_ctrl;
  ctrl_t            ex_q;
  ctrl_t            mem_q;
  ctrl_t            wb_q;
  logic             uses_rs;
  logic             uses_rt;
  logic             load_use;
  fsm_e             state_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_decode u_decode (
    .op_i      (bus.id_opcode[3:0]),
    .ctrl_o    (id_ctrl),
    .uses_rs_o (uses_rs),
    .uses_rt_o (uses_rt)
  );

  assign load_use = ex_q.mem_read && (bus.ex_rd != '0) &&
                    ((uses_rs && (bus.ex_rd == bus.id_rs)) ||
                     (uses_rt && (bus.ex_rd == bus.id_rt)));

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_q    <= CTRL_BUBBLE;
      mem_q   <= CTRL_BUBBLE;
      wb_q    <= CTRL_BUBBLE;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (!bus.mem_stall_i) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      ex_q  <= CTRL_BUBBLE;
      case (state_q)
        RUN: begin
          if (!bus.flush_i && !load_use) begin
            // HLT itself never enters EX; it only starts the drain.
            if (id_ctrl.halt) begin
              state_q <= DRAIN;
              cnt_q   <= CNT_W'(DRAIN_CYC - 1);
            end else begin
              ex_q <= id_ctrl;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == '0) state_q <= HALTED;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_regdst   = ex_q.regdst;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_brsrc    = ex_q.brsrc;
  assign bus.ex_pcs      = ex_q.pcs;
  assign bus.mem_read    = mem_q.mem_read;
  assign bus.mem_write   = mem_q.mem_write;
  assign bus.wb_regwrite = wb_q.regwrite;
  assign bus.wb_memtoreg = wb_q.memtoreg;
  assign bus.halted_o    = (state_q == HALTED);
  assign bus.stall_o     = !rst && (bus.mem_stall_i || (state_q != RUN) ||
                                    (!bus.flush_i && load_use));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: opcode-level reference pipeline feeding
// an expected-output queue, plus directed halt/reset checks.
`timescale 1ns/1ps
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if bus ();

  ctrl_pipe #(.DRAIN_CYC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [13:0] exp_q[$];

  // Reference pipeline tracked as opcodes with valid bits.
  logic [3:0] m_op[3];
  logic       m_v[3];
  int         m_mode;   // 0 run, 1 drain, 2 halted
  int         m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // {aluop[2:0], alusrc, regdst, branch, brsrc, pcs, mem_read, mem_write, regwrite, memtoreg}
  function automatic logic [11:0] dec(input logic [3:0] op);
    logic [11:0] c;
    c = '0;
    if (op < 4'h8) c = {op[2:0], (op >= 4'h4 && op <= 4'h6), 1'b1, 7'b0000010};
    else begin
      case (op)
        4'h8:       c = 12'b000_1_0_0_0_0_1_0_1_1;
        4'h9:       c = 12'b000_1_0_0_0_0_0_1_0_0;
        4'hA, 4'hB: c = 12'b000_1_0_0_0_0_0_0_1_0;
        4'hC:       c = 12'b000_0_0_1_0_0_0_0_0_0;
        4'hD:       c = 12'b000_0_0_1_1_0_0_0_0_0;
        4'hE:       c = 12'b000_0_1_0_0_1_0_0_1_0;
        default:    c = '0;
      endcase
    end
    return c;
  endfunction

  function automatic logic urs(input logic [3:0] op);
    return (op <= 4'h9) || (op == 4'hD);
  endfunction

  function automatic logic urt(input logic [3:0] op);
    return (op <= 4'h3) || (op == 4'h9);
  endfunction

  function automatic logic [13:0] outs();
    return {bus.ex_aluop, bus.ex_alusrc, bus.ex_regdst, bus.ex_branch, bus.ex_brsrc,
            bus.ex_pcs, bus.mem_read, bus.mem_write, bus.wb_regwrite, bus.wb_memtoreg,
            bus.stall_o, bus.halted_o};
  endfunction

  task automatic cyc(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                     input logic [3:0] exrd, input logic fl, input logic ms, input logic r,
                     input string tag);
    logic [11:0] e_ex, e_mem, e_wb;
    logic        lu, stall;
    logic [13:0] e;
    bus.id_opcode = op;  bus.id_rs = rs;  bus.id_rt = rt;  bus.ex_rd = exrd;
    bus.flush_i = fl;    bus.mem_stall_i = ms;  rst = r;
    e_ex  = m_v[0] ? dec(m_op[0]) : '0;
    e_mem = m_v[1] ? dec(m_op[1]) : '0;
    e_wb  = m_v[2] ? dec(m_op[2]) : '0;
    lu = m_v[0] && (m_op[0] == 4'h8) && (exrd != 4'h0) &&
         ((urs(op) && exrd == rs) || (urt(op) && exrd == rt));
    stall = ms || (m_mode != 0) || (!fl && lu);
    exp_q.push_back({e_ex[11:4], e_mem[3:2], e_wb[1:0], stall, (m_mode == 2)});
    @(negedge clk);
    e = exp_q.pop_front();
    if (!r) check(tag, {18'd0, outs()}, {18'd0, e});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
      m_mode = 0;
      m_left = 0;
    end else if (!ms) begin
      m_op[2] = m_op[1];  m_v[2] = m_v[1];
      m_op[1] = m_op[0];  m_v[1] = m_v[0];
      m_v[0]  = 1'b0;
      if (m_mode == 0) begin
        if (!fl && !lu) begin
          if (op == 4'hF) begin
            m_mode = 1;
            m_left = 2;
          end else begin
            m_op[0] = op;
            m_v[0]  = 1'b1;
          end
        end
      end else if (m_mode == 1) begin
        if (m_left == 0) m_mode = 2;
        else             m_left--;
      end
    end
    #1;
  endtask

  task automatic step_op(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] exrd, input string tag);
    cyc(op, rs, rt, exrd, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_mtr;
    logic [3:0] op, rs, rt, rd;
    logic fl, ms, r;

    for (int i = 0; i < 3; i++) begin m_v[i] = 1'b0; m_op[i] = 4'h0; end
    m_mode = 0;
    m_left = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(4'hB, 0, 0, 0, 1'b0, 1'b0, 1'b1, "rst");
    cyc(4'hB, 0, 0, 0, 1'b0, 1'b0, 1'b1, "rst");
    rst = 1'b0; bus.flush_i = 1'b0; bus.mem_stall_i = 1'b0;
    check("reset_outs", {18'd0, outs()}, 32'd0);

    // ADD then SW
    step_op(4'h0, 1, 2, 0, "add_id");
    step_op(4'h9, 1, 2, 0, "sw_id");
    repeat (3) step_op(4'hB, 0, 0, 0, "add_sw_drain");

    // Load-use on rs, then the same with rd = 0
    step_op(4'h8, 1, 0, 0, "lw_rs");
    step_op(4'h0, 3, 4, 3, "lu_rs_stall");
    step_op(4'h0, 3, 4, 0, "lu_rs_hold");
    step_op(4'hB, 0, 0, 0, "lu_rs_after");
    step_op(4'h8, 1, 0, 0, "lw_r0");
    step_op(4'h0, 0, 4, 0, "lu_r0_nostall");
    step_op(4'hB, 0, 0, 0, "lu_r0_after");

    // Load-use on rt; LLB reads neither source
    step_op(4'h8, 1, 0, 0, "lw_rt");
    step_op(4'h1, 5, 6, 6, "lu_rt_stall");
    step_op(4'h1, 5, 6, 0, "lu_rt_hold");
    step_op(4'h8, 1, 0, 0, "lw_llb");
    step_op(4'hA, 6, 6, 6, "llb_nouse");
    step_op(4'hB, 0, 0, 0, "llb_after");

    // Flush squashes HLT in ID
    step_op(4'hD, 2, 0, 0, "br_id");
    cyc(4'hF, 0, 0, 0, 1'b1, 1'b0, 1'b0, "flush_hlt");
    repeat (3) step_op(4'hB, 0, 0, 0, "flush_after");
    check("flush_not_halted", {31'd0, bus.halted_o}, 32'd0);

    // Memory freeze during LW/SW traffic
    step_op(4'h8, 1, 0, 0, "ms_lw");
    step_op(4'h9, 2, 3, 7, "ms_sw");
    repeat (4) cyc(4'h0, 1, 2, 7, 1'b1, 1'b1, 1'b0, "ms_frozen");
    step_op(4'h0, 1, 2, 7, "ms_resume");
    repeat (3) step_op(4'hB, 0, 0, 0, "ms_drain");

    // HLT after LW: drain, halt, stay halted
    step_op(4'h8, 1, 0, 0, "lw_hlt");
    step_op(4'hF, 0, 0, 5, "hlt_id");
    n = 0;
    seen_mtr = 1'b0;
    for (int i = 0; i < 8 && !bus.halted_o; i++) begin
      if (bus.wb_memtoreg) seen_mtr = 1'b1;
      step_op(4'hB, 0, 0, 0, "hlt_drain");
      n++;
    end
    check("halt_latency", n, 3);
    check("memtoreg_before_halt", {31'd0, seen_mtr}, 32'd1);
    repeat (2) step_op(4'h0, 0, 0, 0, "halted_sticky");
    cyc(4'hB, 0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_halted");
    step_op(4'hB, 0, 0, 0, "run_after_halt");

    // Reset in DRAIN, with a freeze cycle inside the drain
    step_op(4'h8, 1, 0, 0, "lw_d");
    step_op(4'hF, 0, 0, 0, "hlt_d");
    cyc(4'hB, 0, 0, 0, 1'b0, 1'b1, 1'b0, "drain_frozen");
    step_op(4'hB, 0, 0, 0, "drain_1");
    cyc(4'hB, 0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_drain");
    bus.flush_i = 1'b0; bus.mem_stall_i = 1'b0;
    check("rst_drain_outs", {18'd0, outs()}, 32'd0);
    step_op(4'hE, 0, 0, 0, "pcs_after_rst");
    step_op(4'hB, 0, 0, 0, "pcs_ex");

    // Random traffic against the reference pipeline
    for (int k = 0; k < 300; k++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) op = 4'hF;
      rs = 4'($urandom_range(0, 3));
      rt = 4'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 3));
      fl = ($urandom_range(0, 7) == 0);
      ms = ($urandom_range(0, 7) == 0);
      r  = (m_mode == 2) && ($urandom_range(0, 2) == 0);
      cyc(op, rs, rt, rd, fl, ms, r, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
